// File: rtl/mxm_rd_gen.sv
// Read-request generator for the matrix X memory: walks vec_size x n_rnds x n_vecs
// reads under credit flow control, then drains outstanding read data before done.
module mxm_rd_gen #(
  parameter int CREDITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_vec_size,
  input  logic [15:0] cfg_n_rnds,
  input  logic [15:0] cfg_n_vecs,
  input  logic        empty,
  input  logic        dout_vld,
  input  logic        cred_ret,
  output logic        rd_en,
  output logic        rd_last_rnd,
  output logic [15:0] vec_size,
  output logic [15:0] vec_size_minus_1,
  output logic        active,
  output logic        done
);

  localparam logic [7:0] CRED_MAX = 8'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] vec_size_q, vec_size_d;
  logic [15:0] vsm1_q, vsm1_d;
  logic [15:0] n_rnds_q, n_rnds_d;
  logic [15:0] n_vecs_q, n_vecs_d;
  logic [15:0] ele_cnt_q, ele_cnt_d;
  logic [15:0] rnd_cnt_q, rnd_cnt_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [7:0]  cred_cnt_q, cred_cnt_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        ele_last, rnd_last, vec_last, ret_ok, vld_ok;

  assign rd_en            = (state_q == S_RUN) && !empty && (cred_cnt_q != 8'd0);
  assign rd_last_rnd      = rnd_last;
  assign vec_size         = vec_size_q;
  assign vec_size_minus_1 = vsm1_q;
  assign active           = active_q;
  assign done             = done_q;

  always_comb begin
    ele_last = (ele_cnt_q == vsm1_q);
    rnd_last = (rnd_cnt_q == n_rnds_q - 16'd1);
    vec_last = (vec_cnt_q == n_vecs_q - 16'd1);

    // a return at full credit is dropped so the count can never overshoot
    ret_ok     = cred_ret && (cred_cnt_q != CRED_MAX);
    cred_cnt_d = cred_cnt_q;
    if (rd_en && !ret_ok)      cred_cnt_d = cred_cnt_q - 8'd1;
    else if (!rd_en && ret_ok) cred_cnt_d = cred_cnt_q + 8'd1;

    vld_ok    = dout_vld && (out_cnt_q != 8'd0);
    out_cnt_d = out_cnt_q;
    if (rd_en && !vld_ok)      out_cnt_d = out_cnt_q + 8'd1;
    else if (!rd_en && vld_ok) out_cnt_d = out_cnt_q - 8'd1;

    state_d    = state_q;
    vec_size_d = vec_size_q;
    vsm1_d     = vsm1_q;
    n_rnds_d   = n_rnds_q;
    n_vecs_d   = n_vecs_q;
    ele_cnt_d  = ele_cnt_q;
    rnd_cnt_d  = rnd_cnt_q;
    vec_cnt_d  = vec_cnt_q;

    case (state_q)
      S_IDLE: begin
        // the done cycle is still treated as busy so a start there is ignored
        if (start && !done_q) begin
          vec_size_d = cfg_vec_size;
          vsm1_d     = cfg_vec_size - 16'd1;
          n_rnds_d   = cfg_n_rnds;
          n_vecs_d   = cfg_n_vecs;
          ele_cnt_d  = 16'd0;
          rnd_cnt_d  = 16'd0;
          vec_cnt_d  = 16'd0;
          if (cfg_vec_size == 16'd0 || cfg_n_rnds == 16'd0 || cfg_n_vecs == 16'd0)
            state_d = S_DONE;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (ele_last) begin
            ele_cnt_d = 16'd0;
            if (rnd_last) begin
              rnd_cnt_d = 16'd0;
              vec_cnt_d = vec_cnt_q + 16'd1;
            end else begin
              rnd_cnt_d = rnd_cnt_q + 16'd1;
            end
          end else begin
            ele_cnt_d = ele_cnt_q + 16'd1;
          end
          if (ele_last && rnd_last && vec_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_d == 8'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_size_q <= 16'd0;
      vsm1_q     <= 16'd0;
      n_rnds_q   <= 16'd0;
      n_vecs_q   <= 16'd0;
      ele_cnt_q  <= 16'd0;
      rnd_cnt_q  <= 16'd0;
      vec_cnt_q  <= 16'd0;
      cred_cnt_q <= CRED_MAX;
      out_cnt_q  <= 8'd0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_size_q <= vec_size_d;
      vsm1_q     <= vsm1_d;
      n_rnds_q   <= n_rnds_d;
      n_vecs_q   <= n_vecs_d;
      ele_cnt_q  <= ele_cnt_d;
      rnd_cnt_q  <= rnd_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      cred_cnt_q <= cred_cnt_d;
      out_cnt_q  <= out_cnt_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mxm_rd_gen.sv
// Bench for mxm_rd_gen: a cycle model tracks read index, credits and outstanding
// data as plain integers and queues, and every cycle is compared against the DUT.
module tb_mxm_rd_gen;
  localparam int CR = 4;

  logic        clk = 1'b0;
  logic        rst, start, empty, dout_vld, cred_ret;
  logic [15:0] cfg_vec_size, cfg_n_rnds, cfg_n_vecs;
  logic        rd_en, rd_last_rnd, active, done;
  logic [15:0] vec_size, vec_size_minus_1;

  always #5 clk = ~clk;

  mxm_rd_gen #(.CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_vec_size(cfg_vec_size), .cfg_n_rnds(cfg_n_rnds), .cfg_n_vecs(cfg_n_vecs),
    .empty(empty), .dout_vld(dout_vld), .cred_ret(cred_ret),
    .rd_en(rd_en), .rd_last_rnd(rd_last_rnd),
    .vec_size(vec_size), .vec_size_minus_1(vec_size_minus_1),
    .active(active), .done(done)
  );

  int vecs = 0, miss = 0, cyc = 0;
  int vld_q[$], ret_q[$];
  bit auto_ret = 1, man_ret = 0;
  int empty_mode = 0;
  bit m_run, m_busy, m_act;
  int m_vs, m_nr, m_nv, m_idx, m_total, m_cred, m_out, exp_done_cyc;
  logic [15:0] m_vsl, m_vsm1;
  int op_reads, rd_while_empty, last_done_cyc, last_vld_cyc;
  logic [11:0] lr_mask;

  task automatic model_reset();
    vld_q.delete(); ret_q.delete();
    m_run = 0; m_busy = 0; m_act = 0; m_idx = 0; m_total = 0;
    m_vs = 1; m_nr = 1; m_nv = 1;
    m_cred = CR; m_out = 0; exp_done_cyc = -1;
    m_vsl = 16'd0; m_vsm1 = 16'd0;
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model at the edge.
  task automatic tick();
    bit exp_rd, exp_lr, ret_ok, acc;
    if (empty_mode == 1)      empty = ((cyc / 2) % 2) == 1;
    else if (empty_mode == 2) empty = ($urandom_range(0, 9) < 3);
    else                      empty = 1'b0;
    dout_vld = (vld_q.size() > 0 && vld_q[0] == cyc);
    if (dout_vld) void'(vld_q.pop_front());
    cred_ret = man_ret;
    if (auto_ret && ret_q.size() > 0 && ret_q[0] == cyc) begin
      cred_ret = 1'b1; void'(ret_q.pop_front());
    end
    @(negedge clk);
    exp_rd = m_run && !empty && (m_cred > 0);
    vecs++;
    if (rd_en !== exp_rd) begin
      miss++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd);
    end
    if (m_run) begin
      exp_lr = ((m_idx / m_vs) % m_nr) == (m_nr - 1);
      vecs++;
      if (rd_last_rnd !== exp_lr) begin
        miss++; $display("FAIL rd_last_rnd cyc=%0d got=%b exp=%b", cyc, rd_last_rnd, exp_lr);
      end
    end
    if (exp_rd) begin
      vecs++;
      if (dut.ele_cnt_q !== 16'(m_idx % m_vs) || dut.rnd_cnt_q !== 16'((m_idx / m_vs) % m_nr)) begin
        miss++; $display("FAIL ele_rnd cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                         dut.ele_cnt_q, dut.rnd_cnt_q, m_idx % m_vs, (m_idx / m_vs) % m_nr);
      end
    end
    if (rd_en === 1'b1) begin
      op_reads++;
      if (empty) rd_while_empty++;
      if (rd_last_rnd === 1'b1 && op_reads <= 12) lr_mask[op_reads-1] = 1'b1;
    end
    if (done === 1'b1) last_done_cyc = cyc;
    if (dout_vld) last_vld_cyc = cyc;
    vecs++;
    if (done !== (cyc == exp_done_cyc)) begin
      miss++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == exp_done_cyc);
    end
    vecs++;
    if (active !== m_act) begin
      miss++; $display("FAIL active cyc=%0d got=%b exp=%b", cyc, active, m_act);
    end
    vecs++;
    if (vec_size !== m_vsl || vec_size_minus_1 !== m_vsm1) begin
      miss++; $display("FAIL vec_size cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                       vec_size, vec_size_minus_1, m_vsl, m_vsm1);
    end
    ret_ok = cred_ret && (m_cred < CR);
    acc    = start && !m_busy;
    if (exp_rd) begin
      m_idx++; m_out++;
      vld_q.push_back(cyc + 3);
      if (auto_ret) ret_q.push_back(cyc + 5);
      if (m_idx == m_total) m_run = 0;
    end
    m_cred = m_cred - (exp_rd ? 1 : 0) + (ret_ok ? 1 : 0);
    if (dout_vld && m_out > 0) begin
      m_out--;
      if (m_out == 0 && !m_run && m_act) begin m_act = 0; exp_done_cyc = cyc + 2; end
    end
    if (cyc == exp_done_cyc) m_busy = 0;
    if (acc) begin
      m_busy = 1; m_vsl = cfg_vec_size; m_vsm1 = cfg_vec_size - 16'd1;
      m_vs = cfg_vec_size; m_nr = cfg_n_rnds; m_nv = cfg_n_vecs; m_idx = 0;
      op_reads = 0; lr_mask = '0;
      if (m_vs == 0 || m_nr == 0 || m_nv == 0) exp_done_cyc = cyc + 2;
      else begin m_run = 1; m_act = 1; m_total = m_vs * m_nr * m_nv; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_op(input int vs, input int nr, input int nv);
    cfg_vec_size = 16'(vs); cfg_n_rnds = 16'(nr); cfg_n_vecs = 16'(nv);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_reads);
    int n = 0;
    while (m_busy && n < 3000) begin tick(); n++; end
    vecs++;
    if (m_busy) begin miss++; $display("FAIL %s timeout got=busy exp=idle", name); end
    vecs++;
    if (op_reads != exp_reads) begin
      miss++; $display("FAIL %s reads got=%0d exp=%0d", name, op_reads, exp_reads);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if (rd_en !== 1'b0 || active !== 1'b0 || done !== 1'b0 || vec_size !== 16'd0 ||
        vec_size_minus_1 !== 16'd0 || dut.cred_cnt_q !== 8'(CR)) begin
      miss++; $display("FAIL reset_state got=%b%b%b vs=%0d cred=%0d exp=000 vs=0 cred=%0d",
                       rd_en, active, done, vec_size, dut.cred_cnt_q, CR);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(3, 2, 2);
    wait_idle("basic", 12);
    vecs++;
    if (lr_mask !== 12'hE38) begin
      miss++; $display("FAIL basic_last_rnd got=%h exp=e38", lr_mask);
    end
    // done shows in the second cycle after the final dout_vld cycle
    vecs++;
    if (last_done_cyc != last_vld_cyc + 2) begin
      miss++; $display("FAIL basic_done_time got=%0d exp=%0d", last_done_cyc, last_vld_cyc + 2);
    end
  endtask

  task automatic test_credit_stall();
    auto_ret = 0;
    run_op(8, 1, 1);
    repeat (8) tick();
    vecs++;
    if (op_reads != 4 || dut.cred_cnt_q !== 8'd0) begin
      miss++; $display("FAIL cred_stall got=%0d/%0d exp=4/0", op_reads, dut.cred_cnt_q);
    end
    man_ret = 1; tick(); man_ret = 0;
    repeat (4) tick();
    vecs++;
    if (op_reads != 5) begin miss++; $display("FAIL cred_one got=%0d exp=5", op_reads); end
    man_ret = 1; tick(); tick();
    vecs++;
    if (op_reads != 6 || dut.cred_cnt_q !== 8'd1) begin
      miss++; $display("FAIL cred_coincide got=%0d/%0d exp=6/1", op_reads, dut.cred_cnt_q);
    end
    wait_idle("cred", 8);
    repeat (6) tick();
    vecs++;
    if (dut.cred_cnt_q !== 8'(CR)) begin
      miss++; $display("FAIL cred_cap got=%0d exp=%0d", dut.cred_cnt_q, CR);
    end
    man_ret = 0; auto_ret = 1;
  endtask

  task automatic test_empty_stall();
    rd_while_empty = 0;
    empty_mode = 1;
    run_op(3, 2, 2);
    wait_idle("empty", 12);
    empty_mode = 0;
    vecs++;
    if (rd_while_empty != 0) begin
      miss++; $display("FAIL empty_rd got=%0d exp=0", rd_while_empty);
    end
  endtask

  task automatic test_zero_cfg();
    int sc;
    sc = cyc;
    run_op(4, 0, 3);
    wait_idle("zero", 0);
    vecs++;
    if (last_done_cyc != sc + 2) begin
      miss++; $display("FAIL zero_done_time got=%0d exp=%0d", last_done_cyc, sc + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    run_op(4, 2, 2);
    while (m_idx < 5 && n < 200) begin tick(); n++; end
    rst = 1'b1; #1;
    vecs++;
    if (rd_en !== 1'b0 || active !== 1'b0 || done !== 1'b0 || dut.cred_cnt_q !== 8'(CR) ||
        vec_size !== 16'd0 || dut.ele_cnt_q !== 16'd0 || dut.out_cnt_q !== 8'd0) begin
      miss++; $display("FAIL mid_reset got=%b%b%b cred=%0d vs=%0d exp=000 cred=%0d vs=0",
                       rd_en, active, done, dut.cred_cnt_q, vec_size, CR);
    end
    model_reset();
    #1 rst = 1'b0;
    repeat (6) tick();
    run_op(1, 1, 1);
    wait_idle("post_reset", 1);
  endtask

  task automatic test_start_busy();
    run_op(2, 3, 2);
    repeat (3) tick();
    cfg_vec_size = 16'd7; start = 1'b1; tick(); start = 1'b0;
    wait_idle("busy", 12);
    vecs++;
    if (vec_size !== 16'd2) begin miss++; $display("FAIL busy_vs got=%0d exp=2", vec_size); end
  endtask

  task automatic test_random();
    int vs, nr, nv;
    empty_mode = 2;
    for (int i = 0; i < 8; i++) begin
      vs = $urandom_range(1, 4); nr = $urandom_range(1, 3); nv = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) vs = 0;
      run_op(vs, nr, nv);
      wait_idle("random", vs * nr * nv);
    end
    empty_mode = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; empty = 1'b0; dout_vld = 1'b0; cred_ret = 1'b0;
    cfg_vec_size = 16'd0; cfg_n_rnds = 16'd0; cfg_n_vecs = 16'd0;
    op_reads = 0; rd_while_empty = 0; last_done_cyc = -1; last_vld_cyc = -1; lr_mask = '0;
    test_reset();
    test_basic();
    test_credit_stall();
    test_empty_stall();
    test_zero_cfg();
    test_reset_mid_run();
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
